// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//   8N1 UART receiver feeding a small byte FIFO, with sticky error flags.
//
// Parameters
//   CLKS_PER_BIT : clock cycles per serial bit (4..65535)
//   DEPTH_LOG2   : log2 of FIFO depth in bytes (>= 1)
//
// Ports
//   clock_50M : sole clock, all logic on the rising edge
//   n_rst     : synchronous active-low reset
//   rx        : asynchronous serial line, idle high, LSB first
//   rd        : pop one byte per asserted cycle (ignored when empty)
//   err_clr   : clears frame_err and overrun (a same-cycle set wins)
//   rx_data   : byte at the FIFO head, valid while rx_ready is high
//   rx_ready  : FIFO non-empty
//   frame_err : sticky, a stop bit was sampled low
//   overrun   : sticky, a received byte was dropped because the FIFO was full
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DEPTH_LOG2   = 2
) (
  input  logic       clock_50M,
  input  logic       n_rst,
  input  logic       rx,
  input  logic       rd,
  input  logic       err_clr,
  output logic [7:0] rx_data,
  output logic       rx_ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam int CW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int DEPTH = 2 ** DEPTH_LOG2;

  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  logic          rx_meta;
  logic          rx_s;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cyc_cnt;
  logic [CW-1:0] cyc_nxt;
  logic [2:0]    bit_cnt;
  logic [2:0]    bit_nxt;
  logic [7:0]    shift_q;
  logic [7:0]    shift_nxt;
  logic          push_pend;
  logic          push_nxt;
  logic          ferr_set;

  logic [DEPTH_LOG2:0] wr_ptr;
  logic [DEPTH_LOG2:0] rd_ptr;
  logic [7:0]          mem [DEPTH];
  logic                fifo_empty;
  logic                fifo_full;
  logic                do_pop;
  logic                do_push;
  logic                ovr_set;

  // Two-flop synchronizer. Both flops reset to the idle level so that a
  // line that is already low at release still needs a visible 1->0 step
  // on rx_s before a start bit is recognised.
  always_ff @(posedge clock_50M) begin
    if (!n_rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // Receiver state, counters, shift register and the one-cycle push strobe.
  // The push is delayed one cycle after the stop-bit sample so the FIFO
  // write sees a stable byte and a clean full/pop decision.
  always_ff @(posedge clock_50M) begin
    if (!n_rst) begin
      state     <= IDLE;
      cyc_cnt   <= '0;
      bit_cnt   <= '0;
      shift_q   <= '0;
      push_pend <= 1'b0;
    end else begin
      state     <= state_nxt;
      cyc_cnt   <= cyc_nxt;
      bit_cnt   <= bit_nxt;
      shift_q   <= shift_nxt;
      push_pend <= push_nxt;
    end
  end

  // Next-state logic. START waits half a bit so every later sample lands
  // near mid-bit; a high line at that point is treated as a glitch.
  // BREAK holds off start detection until the line returns high.
  always_comb begin
    state_nxt = state;
    cyc_nxt   = cyc_cnt;
    bit_nxt   = bit_cnt;
    shift_nxt = shift_q;
    push_nxt  = 1'b0;
    ferr_set  = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          cyc_nxt   = '0;
          state_nxt = START;
        end
      end
      START: begin
        if (cyc_cnt == HALF_LAST) begin
          cyc_nxt   = '0;
          bit_nxt   = '0;
          state_nxt = rx_s ? IDLE : DATA;
        end else begin
          cyc_nxt = cyc_cnt + 1'b1;
        end
      end
      DATA: begin
        if (cyc_cnt == BIT_LAST) begin
          cyc_nxt            = '0;
          shift_nxt[bit_cnt] = rx_s;
          if (bit_cnt == 3'd7) begin
            state_nxt = STOP;
          end else begin
            bit_nxt = bit_cnt + 3'd1;
          end
        end else begin
          cyc_nxt = cyc_cnt + 1'b1;
        end
      end
      STOP: begin
        if (cyc_cnt == BIT_LAST) begin
          cyc_nxt = '0;
          if (rx_s) begin
            push_nxt  = 1'b1;
            state_nxt = IDLE;
          end else begin
            ferr_set  = 1'b1;
            state_nxt = BREAK;
          end
        end else begin
          cyc_nxt = cyc_cnt + 1'b1;
        end
      end
      BREAK: begin
        if (rx_s) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  // A push into a full FIFO still succeeds when a pop happens in the same
  // cycle; the write then lands in the slot being vacated.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                      (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
  assign do_pop     = rd & ~fifo_empty;
  assign do_push    = push_pend & (~fifo_full | do_pop);
  assign ovr_set    = push_pend & fifo_full & ~do_pop;

  assign rx_ready   = ~fifo_empty;
  assign rx_data    = mem[rd_ptr[DEPTH_LOG2-1:0]];

  // FIFO pointers.
  always_ff @(posedge clock_50M) begin
    if (!n_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // FIFO storage, cleared on reset so rx_data is never X.
  always_ff @(posedge clock_50M) begin
    if (!n_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (do_push) begin
      mem[wr_ptr[DEPTH_LOG2-1:0]] <= shift_q;
    end
  end

  // Sticky error flags; a new event outranks a simultaneous clear.
  always_ff @(posedge clock_50M) begin
    if (!n_rst) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (ferr_set) begin
        frame_err <= 1'b1;
      end else if (err_clr) begin
        frame_err <= 1'b0;
      end
      if (ovr_set) begin
        overrun <= 1'b1;
      end else if (err_clr) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo
//   Directed bench for uart_rx_fifo with CLKS_PER_BIT=8, DEPTH_LOG2=2.
//   Inputs change on the falling edge and outputs are sampled there too.
module tb_uart_rx_fifo;

  localparam int CPB = 8;

  logic       clock_50M;
  logic       n_rst;
  logic       rx;
  logic       rd;
  logic       err_clr;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;

  int errors;
  int checks;

  uart_rx_fifo #(
    .CLKS_PER_BIT(CPB),
    .DEPTH_LOG2  (2)
  ) dut (
    .clock_50M(clock_50M),
    .n_rst    (n_rst),
    .rx       (rx),
    .rd       (rd),
    .err_clr  (err_clr),
    .rx_data  (rx_data),
    .rx_ready (rx_ready),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  // 100 MHz-ish simulation clock; absolute period is irrelevant here.
  initial clock_50M = 1'b0;
  always #5 clock_50M = ~clock_50M;

  // Drive one full 8N1 frame starting at a falling edge. When pop_at_push
  // is set, rd is raised for exactly the cycle in which the receiver
  // pushes this byte into the FIFO.
  task automatic send_byte(input logic [7:0] b, input logic stop_val,
                           input logic pop_at_push);
    rx = 1'b0;
    repeat (CPB) @(negedge clock_50M);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clock_50M);
    end
    rx = stop_val;
    repeat (CPB - 1) @(negedge clock_50M);
    rd = pop_at_push;
    @(negedge clock_50M);
    rd = 1'b0;
  endtask

  task automatic pop_byte();
    rd = 1'b1;
    @(negedge clock_50M);
    rd = 1'b0;
  endtask

  task automatic pulse_err_clr();
    err_clr = 1'b1;
    @(negedge clock_50M);
    err_clr = 1'b0;
  endtask

  // Outputs after a plain reset.
  task automatic test_reset();
    n_rst   = 1'b0;
    rx      = 1'b1;
    rd      = 1'b0;
    err_clr = 1'b0;
    repeat (4) @(negedge clock_50M);
    n_rst = 1'b1;
    repeat (4) @(negedge clock_50M);
    checks++;
    if (rx_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_ready: got %b expected 0", rx_ready);
    end
    checks++;
    if (rx_data !== 8'h00) begin
      errors++; $display("[TB] FAIL reset_data: got %h expected 00", rx_data);
    end
    checks++;
    if (frame_err !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_frame_err: got %b expected 0", frame_err);
    end
    checks++;
    if (overrun !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_overrun: got %b expected 0", overrun);
    end
  endtask

  // One good byte in, one byte out.
  task automatic test_single();
    send_byte(8'hA5, 1'b1, 1'b0);
    checks++;
    if (rx_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL single_ready: got %b expected 1", rx_ready);
    end
    checks++;
    if (rx_data !== 8'hA5) begin
      errors++; $display("[TB] FAIL single_data: got %h expected a5", rx_data);
    end
    pop_byte();
    checks++;
    if (rx_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL single_empty: got %b expected 0", rx_ready);
    end
    checks++;
    if (frame_err !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_flags: got fe=%b ov=%b expected 0 0", frame_err, overrun);
    end
  endtask

  // Five bytes with no reads: the fifth is dropped and overrun latches.
  task automatic test_overrun();
    logic [7:0] sent [5];
    sent[0] = 8'h55; sent[1] = 8'h01; sent[2] = 8'hFF;
    sent[3] = 8'h80; sent[4] = 8'h3C;
    for (int i = 0; i < 5; i++) begin
      send_byte(sent[i], 1'b1, 1'b0);
    end
    checks++;
    if (overrun !== 1'b1) begin
      errors++; $display("[TB] FAIL overrun_set: got %b expected 1", overrun);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rx_ready !== 1'b1 || rx_data !== sent[i]) begin
        errors++;
        $display("[TB] FAIL overrun_read%0d: got ready=%b data=%h expected 1 %h",
                 i, rx_ready, rx_data, sent[i]);
      end
      pop_byte();
    end
    checks++;
    if (rx_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL overrun_drained: got %b expected 0", rx_ready);
    end
    pulse_err_clr();
    checks++;
    if (overrun !== 1'b0) begin
      errors++; $display("[TB] FAIL overrun_clear: got %b expected 0", overrun);
    end
  endtask

  // Bad stop bit followed by a long break, then a good byte.
  task automatic test_frame_err();
    send_byte(8'h42, 1'b0, 1'b0);
    rx = 1'b0;
    repeat (40) @(negedge clock_50M);
    rx = 1'b1;
    repeat (16) @(negedge clock_50M);
    send_byte(8'h17, 1'b1, 1'b0);
    checks++;
    if (frame_err !== 1'b1) begin
      errors++; $display("[TB] FAIL frame_err_set: got %b expected 1", frame_err);
    end
    checks++;
    if (rx_ready !== 1'b1 || rx_data !== 8'h17) begin
      errors++;
      $display("[TB] FAIL frame_err_data: got ready=%b data=%h expected 1 17", rx_ready, rx_data);
    end
    pop_byte();
    checks++;
    if (rx_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL frame_err_only_one: got %b expected 0", rx_ready);
    end
    pulse_err_clr();
    checks++;
    if (frame_err !== 1'b0) begin
      errors++; $display("[TB] FAIL frame_err_clear: got %b expected 0", frame_err);
    end
  endtask

  // A short low pulse is rejected and the receiver still takes the next frame.
  task automatic test_glitch();
    rx = 1'b0;
    repeat (3) @(negedge clock_50M);
    rx = 1'b1;
    repeat (20) @(negedge clock_50M);
    checks++;
    if (rx_ready !== 1'b0 || frame_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL glitch_reject: got ready=%b fe=%b expected 0 0", rx_ready, frame_err);
    end
    send_byte(8'h3A, 1'b1, 1'b0);
    checks++;
    if (rx_ready !== 1'b1 || rx_data !== 8'h3A) begin
      errors++;
      $display("[TB] FAIL glitch_recover: got ready=%b data=%h expected 1 3a", rx_ready, rx_data);
    end
    pop_byte();
  endtask

  // Full FIFO, pop lands in the same cycle as the fifth push.
  task automatic test_back_to_back();
    logic [7:0] expect_q [4];
    send_byte(8'h11, 1'b1, 1'b0);
    send_byte(8'h22, 1'b1, 1'b0);
    send_byte(8'h33, 1'b1, 1'b0);
    send_byte(8'h44, 1'b1, 1'b0);
    send_byte(8'h99, 1'b1, 1'b1);
    checks++;
    if (overrun !== 1'b0) begin
      errors++; $display("[TB] FAIL b2b_overrun: got %b expected 0", overrun);
    end
    expect_q[0] = 8'h22; expect_q[1] = 8'h33;
    expect_q[2] = 8'h44; expect_q[3] = 8'h99;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rx_ready !== 1'b1 || rx_data !== expect_q[i]) begin
        errors++;
        $display("[TB] FAIL b2b_read%0d: got ready=%b data=%h expected 1 %h",
                 i, rx_ready, rx_data, expect_q[i]);
      end
      pop_byte();
    end
    checks++;
    if (rx_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL b2b_drained: got %b expected 0", rx_ready);
    end
  endtask

  // Reset asserted during bit 4 of 0x3C and held to the end of that frame.
  task automatic test_reset_mid_frame();
    logic [7:0] b;
    send_byte(8'h5A, 1'b1, 1'b0);
    send_byte(8'h66, 1'b0, 1'b0);
    rx = 1'b1;
    repeat (16) @(negedge clock_50M);
    b = 8'h3C;
    rx = 1'b0;
    repeat (CPB) @(negedge clock_50M);
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clock_50M);
    end
    rx = b[4];
    repeat (2) @(negedge clock_50M);
    n_rst   = 1'b0;
    rd      = 1'b1;
    err_clr = 1'b1;
    repeat (2) @(negedge clock_50M);
    checks++;
    if (rx_ready !== 1'b0 || rx_data !== 8'h00 || frame_err !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset_outputs: got ready=%b data=%h fe=%b ov=%b expected 0 00 0 0",
               rx_ready, rx_data, frame_err, overrun);
    end
    repeat (CPB - 4) @(negedge clock_50M);
    for (int i = 5; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clock_50M);
    end
    rx = 1'b1;
    repeat (CPB) @(negedge clock_50M);
    n_rst   = 1'b1;
    rd      = 1'b0;
    err_clr = 1'b0;
    repeat (16) @(negedge clock_50M);
    checks++;
    if (rx_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL midreset_no_push: got %b expected 0", rx_ready);
    end
    send_byte(8'h81, 1'b1, 1'b0);
    checks++;
    if (rx_ready !== 1'b1 || rx_data !== 8'h81) begin
      errors++;
      $display("[TB] FAIL midreset_next: got ready=%b data=%h expected 1 81", rx_ready, rx_data);
    end
    pop_byte();
    checks++;
    if (rx_ready !== 1'b0 || frame_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset_only_one: got ready=%b fe=%b expected 0 0", rx_ready, frame_err);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    $display("[TB] starting uart_rx_fifo directed tests");
    test_reset();
    test_single();
    test_overrun();
    test_frame_err();
    test_glitch();
    test_back_to_back();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, clock cycles per bit (50 MHz / 115200 baud); legal range 4..65535.
REQ-002 SHALL have parameter DEPTH_LOG2, default 2, FIFO depth = 2**DEPTH_LOG2 bytes (4).
REQ-003 SHALL have port clock_50M  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port n_rst  input  1  reset; synchronous, active-low.
REQ-005 SHALL have port rx  input  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-006 SHALL have port rd  input  1  pop request; one byte per asserted cycle.
REQ-007 SHALL have port err_clr  input  1  clears sticky error flags.
REQ-008 SHALL have port rx_data  output  8  byte at FIFO head, valid while rx_ready=1.
REQ-009 SHALL have port rx_ready  output  1  FIFO non-empty.
REQ-010 SHALL have port frame_err  output  1  sticky; a stop bit sampled low.
REQ-011 SHALL have port overrun  output  1  sticky; a byte dropped because the FIFO was full.

Function
REQ-012 SHALL pass rx through a 2-flop synchronizer; all decisions use the synchronized value rx_s.
REQ-013 SHALL implement FSM states IDLE, START, DATA, STOP, BREAK with one bit counter (0..7) and one cycle counter (width to hold CLKS_PER_BIT-1).
REQ-014 IDLE: on rx_s=0 SHALL clear the cycle counter and enter START.
REQ-015 START: at count CLKS_PER_BIT/2-1 (floor), SHALL sample rx_s; 0 -> DATA with cycle counter cleared; 1 -> IDLE (glitch rejected, nothing pushed).
REQ-016 DATA: every CLKS_PER_BIT cycles SHALL sample rx_s into bit[bit counter], LSB first; after bit 7 -> STOP.
REQ-017 STOP: after CLKS_PER_BIT cycles SHALL sample rx_s; 1 -> push byte, go IDLE; 0 -> discard byte, set frame_err, go BREAK.
REQ-018 BREAK: SHALL remain until rx_s=1, then go IDLE; no new start is detected while in BREAK.
REQ-019 Push SHALL write the FIFO in the cycle after the stop-bit sample; rx_ready SHALL be 1 in the following cycle.
REQ-020 rx_data SHALL show mem[rd_ptr] combinationally from registered storage; undefined content when empty is permitted but SHALL NOT be X after reset (storage reset to 0).
REQ-021 rd with rx_ready=1 SHALL advance rd_ptr at the clock edge; rd with FIFO empty SHALL be ignored (no pointer change, no flag).
REQ-022 Push with FIFO full and no pop in the same cycle SHALL drop the new byte, keep FIFO contents, set overrun.
REQ-023 Simultaneous push and pop SHALL both succeed, occupancy unchanged, no overrun, including when full.
REQ-024 Pointers SHALL be DEPTH_LOG2+1 bits and wrap modulo 2*depth; full = MSBs differ and remaining bits equal; empty = equal.
REQ-025 err_clr SHALL clear frame_err and overrun next cycle; a set event in the same cycle as err_clr SHALL win (flag stays 1).

Reset
REQ-026 With n_rst=0 at a clock edge: FSM=IDLE, counters=0, synchronizer flops=1, pointers=0, storage=0, rx_ready=0, rx_data=0x00, frame_err=0, overrun=0.
REQ-027 Reset mid-frame SHALL abandon the frame without pushing; after release, receiving resumes only on a new falling edge of rx_s.
REQ-028 Inputs rd, err_clr SHALL have no effect while n_rst=0.

Verification (CLKS_PER_BIT=8, DEPTH_LOG2=2)
REQ-029 Send 0xA5 with valid stop -> rx_ready=1 with rx_data=0xA5; rd one cycle -> rx_ready=0; frame_err=0, overrun=0.
REQ-030 Send 0x55, 0x01, 0xFF, 0x80, 0x3C without rd -> first four read back in order 0x55, 0x01, 0xFF, 0x80; 0x3C lost; overrun=1.
REQ-031 Send 0x42 with stop bit low, hold rx low 40 cycles, then high, then send 0x17 -> frame_err=1, FIFO holds only 0x17; err_clr -> frame_err=0.
REQ-032 Low pulse of 3 cycles on idle line -> no push, FSM back to IDLE, rx_ready=0.
REQ-033 FIFO full, assert rd in the exact push cycle of a fifth byte 0x99 -> overrun=0, FIFO holds bytes 2..4 plus 0x99.
REQ-034 Assert n_rst=0 during bit 4 of 0x3C, release, send 0x81 -> only 0x81 received; all outputs 0 during reset.
